// File: rtl/sigma_pipe_pkg.sv
// sigma_pkg: shared constants for the sigma_pipe datapath.
// Mode encoding, reset configuration (SHA-256 big Sigma0) and the
// well-known SHA-2 amount/mode sets for use by benches and integrators.
package sigma_pkg;

  // Per-term mode encoding (bit i of the mode word selects term i's op).
  localparam logic SIGMA_ROTR = 1'b0;
  localparam logic SIGMA_SHR  = 1'b1;

  // Reset configuration: SHA-256 big Sigma0.
  localparam int unsigned SIGMA_RST_AMT0 = 32'd2;
  localparam int unsigned SIGMA_RST_AMT1 = 32'd13;
  localparam int unsigned SIGMA_RST_AMT2 = 32'd22;
  localparam logic [2:0]  SIGMA_RST_MODE = 3'b000;

  // SHA-256 amount sets {a0, a1, a2} and modes.
  localparam int unsigned SHA256_BSIG0_AMT [3] = '{32'd2,  32'd13, 32'd22};
  localparam int unsigned SHA256_BSIG1_AMT [3] = '{32'd6,  32'd11, 32'd25};
  localparam int unsigned SHA256_SSIG0_AMT [3] = '{32'd7,  32'd18, 32'd3};
  localparam int unsigned SHA256_SSIG1_AMT [3] = '{32'd17, 32'd19, 32'd10};

  // SHA-512 amount sets {a0, a1, a2}.
  localparam int unsigned SHA512_BSIG0_AMT [3] = '{32'd28, 32'd34, 32'd39};
  localparam int unsigned SHA512_BSIG1_AMT [3] = '{32'd14, 32'd18, 32'd41};
  localparam int unsigned SHA512_SSIG0_AMT [3] = '{32'd1,  32'd8,  32'd7};
  localparam int unsigned SHA512_SSIG1_AMT [3] = '{32'd19, 32'd61, 32'd6};

  // Big sigmas rotate on all three terms; small sigmas shift on term 2.
  localparam logic [2:0] SIGMA_MODE_BIG   = 3'b000;
  localparam logic [2:0] SIGMA_MODE_SMALL = 3'b100;

endpackage

// File: rtl/sigma_pipe_term.sv
// sigma_term: one combinational sigma term, y = ROTR(x, amt) or SHR(x, amt).
// A zero rotate amount selects x directly so no shift by DATA_W is formed.
module sigma_term
  import sigma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [AMT_W-1:0]  amt_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] y_o
);

  localparam logic [AMT_W:0] WIDTH_C = (AMT_W + 1)'(DATA_W);

  logic [AMT_W:0]      inv_amt_s;
  logic [DATA_W-1:0]   shr_s;
  logic [DATA_W-1:0]   rotr_s;

  // Form both candidate results and pick one by mode.
  always_comb begin
    inv_amt_s = WIDTH_C - {1'b0, amt_i};
    shr_s     = x_i >> amt_i;
    if (amt_i == {AMT_W{1'b0}}) begin
      rotr_s = x_i;
    end else begin
      rotr_s = shr_s | (x_i << inv_amt_s);
    end
    if (mode_i == SIGMA_SHR) begin
      y_o = shr_s;
    end else begin
      y_o = rotr_s;
    end
  end

endmodule

// File: rtl/sigma_pipe.sv
// sigma_pipe: 2-stage streaming sigma unit, out = T0(x) ^ T1(x) ^ T2(x).
// Stage 1 registers the three terms, stage 2 registers their XOR.
// Config (amounts/modes) is latched on `run` and applies to items
// accepted from the following cycle. Optional transfer counter is
// enabled with the macro SIGMA_PIPE_CNT_EN.
module sigma_pipe
  import sigma_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [31:0]       constant_00,
  input  logic [31:0]       constant_01,
  input  logic [31:0]       constant_02,
  input  logic [31:0]       constant_03,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0,
  output logic              busy
`ifdef SIGMA_PIPE_CNT_EN
  ,
  output logic [31:0]       count
`endif
);

  // Configuration registers.
  logic [2:0][AMT_W-1:0] amt_q, amt_d;
  logic [2:0]            mode_q, mode_d;

  // Pipeline state.
  logic                   s1_valid_q, s1_valid_d;
  logic [2:0][DATA_W-1:0] term_q, term_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]      out_q, out_d;

  // Combinational terms and handshake.
  logic [2:0][DATA_W-1:0] term_s;
  logic                   adv1_s;
  logic                   adv2_s;

  // Upper constant bits carry no meaning for this unit.
  logic unused_const_s;
  assign unused_const_s = ^{constant_00[31:AMT_W], constant_01[31:AMT_W],
                            constant_02[31:AMT_W], constant_03[31:3]};

  // Backpressure chain; in0_ready never looks at in0_valid.
  always_comb begin
    adv2_s    = !s2_valid_q || out0_ready;
    adv1_s    = !s1_valid_q || adv2_s;
    in0_ready = adv1_s;
  end

  // Next config: load from the constants on run, otherwise hold.
  always_comb begin
    amt_d  = amt_q;
    mode_d = mode_q;
    if (run) begin
      amt_d[0] = constant_00[AMT_W-1:0];
      amt_d[1] = constant_01[AMT_W-1:0];
      amt_d[2] = constant_02[AMT_W-1:0];
      mode_d   = constant_03[2:0];
    end else begin
      amt_d  = amt_q;
      mode_d = mode_q;
    end
  end

  // Config register; resets to SHA-256 big Sigma0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      amt_q[0] <= AMT_W'(SIGMA_RST_AMT0);
      amt_q[1] <= AMT_W'(SIGMA_RST_AMT1);
      amt_q[2] <= AMT_W'(SIGMA_RST_AMT2);
      mode_q   <= SIGMA_RST_MODE;
    end else begin
      amt_q  <= amt_d;
      mode_q <= mode_d;
    end
  end

  // Three term generators fed from the current (pre-run) config.
  for (genvar gi = 0; gi < 3; gi++) begin : g_term
    sigma_term #(
      .DATA_W (DATA_W),
      .AMT_W  (AMT_W)
    ) u_term (
      .x_i    (in0),
      .amt_i  (amt_q[gi]),
      .mode_i (mode_q[gi]),
      .y_o    (term_s[gi])
    );
  end

  // Stage 1 next state: capture terms when advancing with a valid input.
  always_comb begin
    s1_valid_d = s1_valid_q;
    term_d     = term_q;
    if (adv1_s) begin
      s1_valid_d = in0_valid;
      if (in0_valid) begin
        term_d = term_s;
      end else begin
        term_d = term_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
      term_d     = term_q;
    end
  end

  // Stage 2 next state: fold terms when advancing with a valid stage 1.
  always_comb begin
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    if (adv2_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = term_q[0] ^ term_q[1] ^ term_q[2];
      end else begin
        out_d = out_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
      out_d      = out_q;
    end
  end

  // Pipeline registers; reset drops all in-flight items.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      term_q     <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      term_q     <= term_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
    end
  end

  // Output drive straight from stage-2 registers.
  always_comb begin
    out0_valid = s2_valid_q;
    out0       = out_q;
    busy       = s1_valid_q || s2_valid_q;
  end

`ifdef SIGMA_PIPE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Transfer counter next state: run clears, else saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      cnt_d = 32'd0;
    end else if (s2_valid_q && out0_ready && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Transfer counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
`endif

endmodule
